// File: rtl/button_irq_pkg.sv
// Shared constants for the push-button interrupt controller: event-mode
// encodings and a clog2 helper that never returns less than one bit.
package button_irq_pkg;

  localparam logic [1:0] MODE_PRESS   = 2'b00;
  localparam logic [1:0] MODE_RELEASE = 2'b01;
  localparam logic [1:0] MODE_BOTH    = 2'b10;
  localparam logic [1:0] MODE_OFF     = 2'b11;

  // Index width for n items; a single item still needs a 1-bit index.
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_irq_ctrl_if.sv
// Bundle of the button controller's board, configuration, acknowledge and
// status signals. The master side drives buttons/config/ack, the slave side
// (the controller) drives the status outputs.
interface button_irq_ctrl_if #(
  parameter int N_BTN = 4,
  parameter int ID_W  = 2
);

  logic [N_BTN-1:0] buttons;
  logic [1:0]       mode;
  logic [N_BTN-1:0] irq_mask;
  logic             ack;
  logic [ID_W-1:0]  ack_id;
  logic [N_BTN-1:0] btn_state;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] overflow;
  logic             irq;
  logic [ID_W-1:0]  irq_id;

  modport master (
    output buttons, mode, irq_mask, ack, ack_id,
    input  btn_state, pending, overflow, irq, irq_id
  );

  modport slave (
    input  buttons, mode, irq_mask, ack, ack_id,
    output btn_state, pending, overflow, irq, irq_id
  );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser followed by a saturating
// stability counter. The output level is in pressed sense (1 = pressed)
// even though the raw board input is active-low.
module btn_debounce
  import button_irq_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level
);

  localparam int CNT_W = clog2w(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pressed_now;

  assign pressed_now = ~sync2_reg;
  assign level       = stable_reg;

  // Synchroniser stages idle at 1 so a released button looks released from reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive disagreeing samples; flip the stable level on the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (pressed_now != stable_reg) begin
      if (cnt_reg == CNT_LAST) begin
        stable_reg <= pressed_now;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      cnt_reg <= '0;
    end
  end

endmodule

// File: rtl/button_irq_ctrl.sv
// Push-button interrupt controller: per-channel debouncing, edge events
// selected by mode, latched pending/overflow flags with ack clearing, and a
// lowest-index-first masked interrupt encoder.
module button_irq_ctrl
  import button_irq_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int DEB_CYCLES = 4,
  parameter int ID_W       = clog2w(N_BTN)
) (
  input  logic clk,
  input  logic reset,
  button_irq_ctrl_if.slave bus
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] prev_reg;
  logic [N_BTN-1:0] pending_reg;
  logic [N_BTN-1:0] overflow_reg;
  logic [N_BTN-1:0] event_w;
  logic [N_BTN-1:0] ack_w;
  logic [N_BTN-1:0] active_w;
  logic [ID_W-1:0]  irq_id_w;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_deb
      btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk   (clk),
        .reset (reset),
        .btn_n (bus.buttons[gi]),
        .level (level_w[gi])
      );
    end
  endgenerate

  // Previous debounced level, used to find edges; zero after reset so an
  // idle board produces no spurious event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_reg <= '0;
    else       prev_reg <= level_w;
  end

  // Edge events filtered by the selected mode.
  always_comb begin
    event_w = '0;
    case (bus.mode)
      MODE_PRESS:   event_w = level_w & ~prev_reg;
      MODE_RELEASE: event_w = ~level_w & prev_reg;
      MODE_BOTH:    event_w = level_w ^ prev_reg;
      default:      event_w = '0;
    endcase
  end

  // Decode the ack strobe into a per-channel clear; out-of-range ids match nothing.
  always_comb begin
    ack_w = '0;
    for (int i = 0; i < N_BTN; i++) begin
      ack_w[i] = bus.ack && (bus.ack_id == ID_W'(i));
    end
  end

  // Pending/overflow flags: a new event beats a same-cycle ack; an event on an
  // already-pending channel marks overflow unless that ack is retiring it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg  <= '0;
      overflow_reg <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (event_w[i]) begin
          pending_reg[i] <= 1'b1;
          if (pending_reg[i] && !ack_w[i]) overflow_reg[i] <= 1'b1;
        end else if (ack_w[i] && pending_reg[i]) begin
          pending_reg[i]  <= 1'b0;
          overflow_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign active_w = pending_reg & bus.irq_mask;

  // Lowest active index wins; scanning downward lets the lowest overwrite last.
  always_comb begin
    irq_id_w = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (active_w[i]) irq_id_w = ID_W'(i);
    end
  end

  assign bus.btn_state = level_w;
  assign bus.pending   = pending_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.irq       = |active_w;
  assign bus.irq_id    = irq_id_w;

endmodule

// File: doc/button_irq_ctrl.md
BUTTON_IRQ_CTRL -- requirements
Module: button_irq_ctrl

Interface
REQ-001 Parameter: N_BTN, 4, number of push-button channels (1..16).
REQ-002 Parameter: DEB_CYCLES, 4, consecutive stable samples required to accept a level change (>=2).
REQ-003 Parameter: ID_W, clog2(N_BTN) (min 1), width of channel index outputs.
REQ-004 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 Port: buttons  input  N_BTN  raw board buttons; active-low, so 1 = released.
REQ-007 Port: mode  input  2  event select: 00 press, 01 release, 10 both, 11 disabled.
REQ-008 Port: irq_mask  input  N_BTN  1 = channel may raise irq.
REQ-009 Port: ack  input  1  single-cycle acknowledge strobe.
REQ-010 Port: ack_id  input  ID_W  channel cleared by ack.
REQ-011 Port: btn_state  output  N_BTN  debounced level; 1 = pressed.
REQ-012 Port: pending  output  N_BTN  latched event flags.
REQ-013 Port: overflow  output  N_BTN  sticky flag: event lost while pending already set.
REQ-014 Port: irq  output  1  OR of (pending & irq_mask).
REQ-015 Port: irq_id  output  ID_W  lowest index with pending & irq_mask set; 0 when irq=0.

Function
REQ-016 Each raw input SHALL pass a 2-flop synchroniser before any other logic.
REQ-017 Per channel, cnt SHALL increment each cycle synchronised level differs from stable level; cnt SHALL clear when they match.
REQ-018 When mismatch persists and cnt == DEB_CYCLES-1, stable level SHALL flip and cnt SHALL clear; raw change -> btn_state change at rising edge 2+DEB_CYCLES.
REQ-019 Glitches shorter than DEB_CYCLES synchronised cycles SHALL produce no btn_state change.
REQ-020 Event = registered btn_state edge matching mode (press 0->1, release 1->0, both either); pending SHALL set one edge after btn_state changes (edge 3+DEB_CYCLES).
REQ-021 mode 11 SHALL generate no events; existing pending/overflow SHALL be retained; mode changes apply from the next edge.
REQ-022 Event on a channel already pending SHALL set its overflow bit; pending stays 1.
REQ-023 ack SHALL clear pending[ack_id] and overflow[ack_id] on the next edge; ack of a non-pending channel or ack_id >= N_BTN SHALL have no effect.
REQ-024 Simultaneous ack and new event on the same channel: set wins, pending stays 1, overflow unchanged.
REQ-025 irq_mask SHALL gate irq/irq_id only, never pending capture.
REQ-026 irq and irq_id SHALL be combinational from pending and irq_mask (zero added latency).

Reset
REQ-027 Reset SHALL force btn_state, pending, overflow, all counters to 0 and both synchroniser stages to 1 (released).
REQ-028 Outputs after reset: irq=0, irq_id=0; no event SHALL be generated on reset release while buttons are released.
REQ-029 Reset mid-debounce or with pending set SHALL discard all in-flight and latched state.

Structure
REQ-030 Package button_irq_pkg SHALL hold mode encoding constants (MODE_PRESS, MODE_RELEASE, MODE_BOTH, MODE_OFF) and the clog2 width helper.
REQ-031 Sub-module btn_debounce (synchroniser + counter + stable level, one channel) SHALL be instantiated N_BTN times via generate.
REQ-032 Event detection, pending/overflow registers and priority encoder SHALL live in button_irq_ctrl.

Verification (N_BTN=4, DEB_CYCLES=4, 60 ns clock)
REQ-033 Reset, buttons=1111 held -> btn_state=0000, pending=0000, irq=0 for 50 cycles.
REQ-034 mode=00, mask=1111, buttons=1110 held -> btn_state=0001 at edge 6, pending=0001, irq=1, irq_id=0 at edge 7; ack, ack_id=0 -> pending=0000, irq=0 next edge.
REQ-035 buttons[1] low for 3 cycles then high -> btn_state[1] stays 0, no pending.
REQ-036 mask=1100, press buttons 0 and 2 together -> pending=0101, irq_id=2; ack id 2 -> irq=0, pending=0001.
REQ-037 mode=10, press then release button 3 without ack -> pending[3]=1, overflow[3]=1; ack id 3 on the cycle a new event arrives -> pending[3] stays 1.
REQ-038 Assert reset 2 cycles into debounce of button 1 -> all outputs 0 immediately; no event after reset release with buttons=1111.
